mul_seq: RTL and testbench

Operand sequencer and result collector wrapped around the 16x16 radix-4 Booth multiplier. Accepts signed operand pairs on a valid/ready input stream and buffers them in a small FIFO. Issues each pair to the multiplier with a one-cycle start pulse, waits for completion via the multiplier's busy flag, then presents the 32-bit product on a valid/ready output stream. Sits directly upstream and downstream of the multiplier, so producers never handle its start/busy protocol.

---
 rtl/mul_seq_pkg.sv | 17 +
 rtl/mul_seq_fifo.sv | 52 +++++
 rtl/mul_seq.sv | 165 ++++++++++++++++
 tb/tb_mul_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the mul_seq operand sequencer.
// Widths, the default abort timeout and the sequencer state encoding.
package mul_seq_pkg;

    localparam int unsigned OP_W        = 16;
    localparam int unsigned PROD_W      = 32;
    localparam int unsigned TIMEOUT_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_e;

endpackage

// File: rtl/mul_seq_fifo.sv
// Synchronous operand FIFO; DEPTH must be a power of two so pointers wrap naturally.
// Simultaneous push and pop are both honoured with the level unchanged.
module mul_seq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            case ({push, pop})
                2'b10:   level_r <= level_r + (AW+1)'(1'b1);
                2'b01:   level_r <= level_r - (AW+1)'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array; contents need no reset
    always_ff @(posedge clk) begin
        if (push) mem_r[wr_ptr_r] <= din;
    end

    assign dout  = mem_r[rd_ptr_r];
    assign level = level_r;
    assign full  = (level_r == (AW+1)'(DEPTH));
    assign empty = (level_r == '0);

endmodule

// File: rtl/mul_seq.sv
// Operand sequencer and result collector around the start/busy Booth multiplier.
// Optional wait-state abort is enabled by defining MUL_SEQ_TIMEOUT_EN.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         in_x,
    input  logic [OP_W-1:0]         in_y,
    output logic                    mul_start,
    output logic [OP_W-1:0]         mul_x,
    output logic [OP_W-1:0]         mul_y,
    input  logic [PROD_W-1:0]       mul_z,
    input  logic                    mul_busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PROD_W-1:0]       out_z,
    output logic                    out_err,
    output logic [$clog2(DEPTH):0]  fifo_level
);

    state_e              state_r;
    state_e              next_s;
    logic                push_s;
    logic                pop_s;
    logic                done_s;
    logic                abort_s;
    logic                timeout_hit_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [2*OP_W-1:0]   head_s;

    assign push_s   = in_valid && in_ready;
    assign in_ready = !fifo_full_s;

    mul_seq_fifo #(
        .DEPTH (DEPTH),
        .W     (2*OP_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   ({in_x, in_y}),
        .dout  (head_s),
        .level (fifo_level),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

`ifdef MUL_SEQ_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt_r;

    // Wait-state cycle counter, restarted whenever the state changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (next_s != state_r) begin
            wait_cnt_r <= '0;
        end else if (state_r == ST_WAIT_BUSY || state_r == ST_WAIT_DONE) begin
            wait_cnt_r <= wait_cnt_r + CW'(1'b1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Counter starts at zero on entry, so TIMEOUT-1 marks the last allowed cycle
    assign timeout_hit_s = (state_r == ST_WAIT_BUSY || state_r == ST_WAIT_DONE) &&
                           (wait_cnt_r == CW'(TIMEOUT - 1));
`else
    logic timeout_unused_s;
    assign timeout_unused_s = (TIMEOUT == 32'd0);
    assign timeout_hit_s    = 1'b0;
`endif

    // Next-state and FIFO pop decode
    always_comb begin
        next_s  = state_r;
        pop_s   = 1'b0;
        done_s  = 1'b0;
        abort_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s  = 1'b1;
                    next_s = ST_ISSUE;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_ISSUE: next_s = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (mul_busy) begin
                    next_s = ST_WAIT_DONE;
                end else if (timeout_hit_s) begin
                    abort_s = 1'b1;
                    next_s  = ST_HOLD;
                end else begin
                    next_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!mul_busy) begin
                    done_s = 1'b1;
                    next_s = ST_HOLD;
                end else if (timeout_hit_s) begin
                    abort_s = 1'b1;
                    next_s  = ST_HOLD;
                end else begin
                    next_s = ST_WAIT_DONE;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_HOLD;
                end
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Operand, start-pulse and result output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_start <= 1'b0;
            mul_x     <= '0;
            mul_y     <= '0;
            out_valid <= 1'b0;
            out_z     <= '0;
            out_err   <= 1'b0;
        end else begin
            mul_start <= (next_s == ST_ISSUE);
            if (pop_s) {mul_x, mul_y} <= head_s;
            if (done_s) begin
                out_z     <= mul_z;
                out_err   <= 1'b0;
                out_valid <= 1'b1;
            end else if (abort_s) begin
                out_z     <= '0;
                out_err   <= 1'b1;
                out_valid <= 1'b1;
            end else if (state_r == ST_HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq with a behavioural start/busy multiplier.
// The timeout scenario runs only when MUL_SEQ_TIMEOUT_EN is defined.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        mul_start;
    logic [15:0] mul_x;
    logic [15:0] mul_y;
    logic [31:0] mul_z;
    logic        mul_busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic        out_err;
    logic [2:0]  fifo_level;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_len = 10;
    bit stuck    = 1'b0;

    logic [15:0] bx [6] = '{16'd1, 16'hFFFF, 16'd100, 16'd12, 16'hFFFD, 16'd256};
    logic [15:0] by [6] = '{16'd2, 16'd7, 16'hFF9C, 16'd12, 16'hFFFD, 16'd256};
    logic [31:0] be [6] = '{32'h0000_0002, 32'hFFFF_FFF9, 32'hFFFF_D8F0,
                            32'h0000_0090, 32'h0000_0009, 32'h0001_0000};

    mul_seq #(.DEPTH(4), .TIMEOUT(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .mul_start  (mul_start),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_z      (mul_z),
        .mul_busy   (mul_busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_err    (out_err),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: busy rises the cycle after start and stays high busy_len cycles
    initial begin
        logic signed [15:0] ox;
        logic signed [15:0] oy;
        logic signed [31:0] prod;
        mul_busy = 1'b0;
        mul_z    = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (mul_start === 1'b1 && !stuck) begin
                ox   = mul_x;
                oy   = mul_y;
                prod = ox * oy;
                @(posedge clk); #1;
                mul_busy = 1'b1;
                mul_z    = prod;
                repeat (busy_len) @(posedge clk);
                #1 mul_busy = 1'b0;
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic push_pair(input logic [15:0] x, input logic [15:0] y);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_checks += 8;
        if (in_ready !== 1'b1)       begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (mul_start !== 1'b0)      begin n_fail++; $display("FAIL reset_mul_start got %b want 0", mul_start); end
        if (mul_x !== 16'd0)         begin n_fail++; $display("FAIL reset_mul_x got %h want 0", mul_x); end
        if (mul_y !== 16'd0)         begin n_fail++; $display("FAIL reset_mul_y got %h want 0", mul_y); end
        if (out_valid !== 1'b0)      begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (out_z !== 32'd0)         begin n_fail++; $display("FAIL reset_out_z got %h want 0", out_z); end
        if (out_err !== 1'b0)        begin n_fail++; $display("FAIL reset_out_err got %b want 0", out_err); end
        if (fifo_level !== 3'd0)     begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        int cnt;
        int extra;
        out_ready = 1'b1;
        push_pair(16'd3, 16'hFFFB);
        n_checks += 2;
        if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level_t1 got %0d want 1", fifo_level); end
        if (mul_start !== 1'b0)  begin n_fail++; $display("FAIL single_start_t1 got %b want 0", mul_start); end
        tick();
        n_checks += 4;
        if (mul_start !== 1'b1)   begin n_fail++; $display("FAIL single_start_t2 got %b want 1", mul_start); end
        if (mul_x !== 16'd3)      begin n_fail++; $display("FAIL single_mul_x got %h want 0003", mul_x); end
        if (mul_y !== 16'hFFFB)   begin n_fail++; $display("FAIL single_mul_y got %h want fffb", mul_y); end
        if (fifo_level !== 3'd0)  begin n_fail++; $display("FAIL single_level_t2 got %0d want 0", fifo_level); end
        cnt   = 0;
        extra = 0;
        while (out_valid !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
            if (mul_start === 1'b1) extra++;
        end
        n_checks += 4;
        if (cnt !== 12)          begin n_fail++; $display("FAIL single_latency got %0d want 12", cnt); end
        if (extra !== 0)         begin n_fail++; $display("FAIL single_pulse_count got %0d want 0 extra", extra); end
        if (out_z !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL single_out_z got %h want fffffff1", out_z); end
        if (out_err !== 1'b0)    begin n_fail++; $display("FAIL single_out_err got %b want 0", out_err); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL single_release got %b want 0", out_valid); end
    endtask

    task automatic test_corner;
        logic [15:0] cx [3] = '{16'h8000, 16'h7FFF, 16'h0000};
        logic [15:0] cy [3] = '{16'h8000, 16'h8000, 16'h1234};
        logic [31:0] ce [3] = '{32'h4000_0000, 32'hC000_8000, 32'h0000_0000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_pair(cx[i], cy[i]);
            for (int c = 0; c < 40 && out_valid !== 1'b1; c++) tick();
            n_checks += 2;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL corner%0d_valid got %b want 1", i, out_valid); end
            if (out_z !== ce[i])    begin n_fail++; $display("FAIL corner%0d_out_z got %h want %h", i, out_z, ce[i]); end
            tick();
        end
    endtask

    task automatic test_backpressure;
        int  i;
        int  k;
        logic acc;
        i = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (i < 6) begin in_valid = 1'b1; in_x = bx[i]; in_y = by[i]; end
            else in_valid = 1'b0;
            acc = in_valid && in_ready;
            tick();
            if (acc) i++;
        end
        n_checks += 5;
        if (i !== 5)             begin n_fail++; $display("FAIL bp_accepted got %0d want 5", i); end
        if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL bp_level got %0d want 4", fifo_level); end
        if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL bp_hold_valid got %b want 1", out_valid); end
        if (out_z !== be[0])     begin n_fail++; $display("FAIL bp_hold_z got %h want %h", out_z, be[0]); end
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 300 && k < 6; c++) begin
            if (i < 6) begin in_valid = 1'b1; in_x = bx[i]; in_y = by[i]; end
            else in_valid = 1'b0;
            acc = in_valid && in_ready;
            if (out_valid === 1'b1) begin
                n_checks++;
                if (out_z !== be[k]) begin n_fail++; $display("FAIL bp_result%0d got %h want %h", k, out_z, be[k]); end
                k++;
            end
            tick();
            if (acc) i++;
        end
        in_valid = 1'b0;
        n_checks += 2;
        if (k !== 6) begin n_fail++; $display("FAIL bp_result_count got %0d want 6", k); end
        if (i !== 6) begin n_fail++; $display("FAIL bp_push_count got %0d want 6", i); end
    endtask

    task automatic test_simul_push_pop;
        logic [31:0] se [3] = '{32'hFFFF_FFFA, 32'hFFFF_FFC8, 32'h000F_4240};
        int k;
        out_ready = 1'b0;
        push_pair(16'd5, 16'd6);
        for (int c = 0; c < 30 && out_valid !== 1'b1; c++) tick();
        n_checks++;
        if (out_z !== 32'h0000_001E) begin n_fail++; $display("FAIL sim_first_z got %h want 0000001e", out_z); end
        push_pair(16'hFFFE, 16'd3);
        push_pair(16'd7, 16'hFFF8);
        n_checks++;
        if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL sim_level_pre got %0d want 2", fifo_level); end
        out_ready = 1'b1;
        tick();
        n_checks += 2;
        if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL sim_idle_valid got %b want 0", out_valid); end
        if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL sim_level_idle got %0d want 2", fifo_level); end
        push_pair(16'd1000, 16'd1000);
        n_checks += 2;
        if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL sim_level_post got %0d want 2", fifo_level); end
        if (mul_x !== 16'hFFFE)  begin n_fail++; $display("FAIL sim_popped_x got %h want fffe", mul_x); end
        k = 0;
        for (int c = 0; c < 200 && k < 3; c++) begin
            if (out_valid === 1'b1) begin
                n_checks++;
                if (out_z !== se[k]) begin n_fail++; $display("FAIL sim_result%0d got %h want %h", k, out_z, se[k]); end
                k++;
            end
            tick();
        end
        n_checks++;
        if (k !== 3) begin n_fail++; $display("FAIL sim_result_count got %0d want 3", k); end
    endtask

    task automatic test_reset_mid;
        int spurious;
        out_ready = 1'b1;
        push_pair(16'd9, 16'd9);
        push_pair(16'd2, 16'd2);
        for (int c = 0; c < 20 && mul_busy !== 1'b1; c++) tick();
        repeat (3) tick();
        n_checks++;
        if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL mid_level_pre got %0d want 1", fifo_level); end
        rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
        if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mid_level got %0d want 0", fifo_level); end
        if (mul_x !== 16'd0)     begin n_fail++; $display("FAIL mid_mul_x got %h want 0", mul_x); end
        if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
        if (out_z !== 32'd0)     begin n_fail++; $display("FAIL mid_out_z got %h want 0", out_z); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (out_valid !== 1'b0 || mul_start !== 1'b0) spurious++;
        end
        n_checks += 2;
        if (spurious !== 0)      begin n_fail++; $display("FAIL mid_spurious got %0d want 0", spurious); end
        if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mid_level_post got %0d want 0", fifo_level); end
    endtask

`ifdef MUL_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int cnt;
        stuck     = 1'b1;
        out_ready = 1'b0;
        push_pair(16'd4, 16'd4);
        for (int c = 0; c < 10 && mul_start !== 1'b1; c++) tick();
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 60) begin
            tick();
            cnt++;
        end
        // 32 cycles in WAIT_BUSY after the start cycle, then the registered result
        n_checks += 3;
        if (cnt !== 33)         begin n_fail++; $display("FAIL to_latency got %0d want 33", cnt); end
        if (out_err !== 1'b1)   begin n_fail++; $display("FAIL to_out_err got %b want 1", out_err); end
        if (out_z !== 32'd0)    begin n_fail++; $display("FAIL to_out_z got %h want 0", out_z); end
        stuck     = 1'b0;
        out_ready = 1'b1;
        tick();
        push_pair(16'd6, 16'd7);
        for (int c = 0; c < 40 && out_valid !== 1'b1; c++) tick();
        n_checks += 3;
        if (out_valid !== 1'b1)       begin n_fail++; $display("FAIL to_next_valid got %b want 1", out_valid); end
        if (out_z !== 32'h0000_002A)  begin n_fail++; $display("FAIL to_next_z got %h want 0000002a", out_z); end
        if (out_err !== 1'b0)         begin n_fail++; $display("FAIL to_next_err got %b want 0", out_err); end
        tick();
    endtask
`endif

    initial begin
        in_valid  = 1'b0;
        in_x      = 16'd0;
        in_y      = 16'd0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_corner();
        test_backpressure();
        test_simul_push_pop();
        test_reset_mid();
`ifdef MUL_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
